// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
// Holds the operation encodings, FSM states and default widths.
package ex_muldiv_ctrl_pkg;

  localparam int unsigned MD_NB_REG = 32;
  localparam int unsigned MD_NB_OP  = 3;
  localparam int unsigned MD_NB_CNT = 6;

  typedef enum logic [2:0] {
    MdMult  = 3'd0,
    MdMultu = 3'd1,
    MdDiv   = 3'd2,
    MdDivu  = 3'd3,
    MdMthi  = 3'd4,
    MdMtlo  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage <-> muldiv sequencer bundle: op issue, MFHI/MFLO read request, flush,
// HI/LO results and busy/done/stall status.
interface ex_muldiv_ctrl_if
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned NB_REG = MD_NB_REG,
  parameter int unsigned NB_OP  = MD_NB_OP
);

  logic              i_start;
  logic [NB_OP-1:0]  i_md_op;
  logic [NB_REG-1:0] i_rs_data;
  logic [NB_REG-1:0] i_rt_data;
  logic              i_read_req;
  logic              i_flush;
  logic [NB_REG-1:0] o_hi;
  logic [NB_REG-1:0] o_lo;
  logic              o_busy;
  logic              o_done;
  logic              o_stall;

  modport master (
    output i_start, i_md_op, i_rs_data, i_rt_data, i_read_req, i_flush,
    input  o_hi, o_lo, o_busy, o_done, o_stall
  );

  modport slave (
    input  i_start, i_md_op, i_rs_data, i_rt_data, i_read_req, i_flush,
    output o_hi, o_lo, o_busy, o_done, o_stall
  );

endinterface

// File: rtl/ex_muldiv_ctrl_iter_core.sv
// Iterative datapath: 64-bit shift register with shift-add multiply and restoring divide.
// Operates on magnitudes only; sign handling lives in the controller.
module ex_muldiv_ctrl_iter_core #(
  parameter int unsigned NB_REG = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_i,
  input  logic [NB_REG-1:0] a_i,
  input  logic [NB_REG-1:0] b_i,
  output logic [NB_REG-1:0] hi_o,
  output logic [NB_REG-1:0] lo_o
);

  logic [NB_REG-1:0] acc_hi_q, acc_hi_d;
  logic [NB_REG-1:0] acc_lo_q, acc_lo_d;
  logic [NB_REG-1:0] b_q, b_d;
  logic [NB_REG:0]   add_sum;
  logic [NB_REG:0]   sub_in;
  logic [NB_REG:0]   sub_diff;

  // Multiply: LO holds the multiplier, consumed LSB first while the sum shifts in from the top.
  assign add_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  // Divide: partial remainder < divisor, so a set MSB of the difference means "restore".
  assign sub_in   = {acc_hi_q, acc_lo_q[NB_REG-1]};
  assign sub_diff = sub_in - {1'b0, b_q};

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    if (clr_i) begin
      acc_hi_d = '0;
      acc_lo_d = '0;
      b_d      = '0;
    end else if (load_i) begin
      acc_hi_d = '0;
      acc_lo_d = a_i;
      b_d      = b_i;
    end else if (step_i) begin
      if (div_i) begin
        if (!sub_diff[NB_REG]) begin
          acc_hi_d = sub_diff[NB_REG-1:0];
          acc_lo_d = {acc_lo_q[NB_REG-2:0], 1'b1};
        end else begin
          acc_hi_d = sub_in[NB_REG-1:0];
          acc_lo_d = {acc_lo_q[NB_REG-2:0], 1'b0};
        end
      end else begin
        acc_hi_d = add_sum[NB_REG:1];
        acc_lo_d = {add_sum[0], acc_lo_q[NB_REG-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
    end
  end

  assign hi_o = acc_hi_q;
  assign lo_o = acc_lo_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer beside EX; owns HI/LO, handles MTHI/MTLO and
// stalls dependent ops while a 32-iteration operation is in flight.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned NB_REG = MD_NB_REG,
  parameter int unsigned NB_OP  = MD_NB_OP,
  parameter int unsigned NB_CNT = MD_NB_CNT
) (
  input logic            i_clk,
  input logic            i_rst_n,
  ex_muldiv_ctrl_if.slave md
);

  md_state_e           state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic                sign_rs_q, sign_rs_d;
  logic                sign_rt_q, sign_rt_d;
  logic                is_div_q, is_div_d;
  logic                dz_q, dz_d;
  logic [NB_REG-1:0]   hi_q, hi_d;
  logic [NB_REG-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic                core_clr, core_load, core_step;
  logic [NB_REG-1:0]   core_hi, core_lo;
  logic [NB_REG-1:0]   mag_rs, mag_rt;
  logic [NB_OP-1:0]    op;
  logic                op_signed;
  logic                busy;
  logic [2*NB_REG-1:0] prod_raw, prod_fix;
  logic [NB_REG-1:0]   quo_fix, rem_fix;

  assign op        = md.i_md_op;
  assign op_signed = (op == NB_OP'(MdMult)) || (op == NB_OP'(MdDiv));
  assign mag_rs    = (op_signed && md.i_rs_data[NB_REG-1]) ? -md.i_rs_data : md.i_rs_data;
  assign mag_rt    = (op_signed && md.i_rt_data[NB_REG-1]) ? -md.i_rt_data : md.i_rt_data;

  assign prod_raw  = {core_hi, core_lo};
  assign prod_fix  = (sign_rs_q ^ sign_rt_q) ? -prod_raw : prod_raw;
  assign quo_fix   = (sign_rs_q ^ sign_rt_q) ? -core_lo : core_lo;
  // Remainder follows the dividend; for x/0 this reproduces the original rs value.
  assign rem_fix   = sign_rs_q ? -core_hi : core_hi;

  ex_muldiv_ctrl_iter_core #(
    .NB_REG (NB_REG)
  ) u_iter_core (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .clr_i  (core_clr),
    .load_i (core_load),
    .step_i (core_step),
    .div_i  (is_div_q),
    .a_i    (mag_rs),
    .b_i    (mag_rt),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sign_rs_d = sign_rs_q;
    sign_rt_d = sign_rt_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    core_clr  = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    if (md.i_flush) begin
      state_d   = StIdle;
      cnt_d     = '0;
      sign_rs_d = 1'b0;
      sign_rt_d = 1'b0;
      is_div_d  = 1'b0;
      dz_d      = 1'b0;
      core_clr  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md.i_start) begin
            case (op)
              NB_OP'(MdMult), NB_OP'(MdMultu), NB_OP'(MdDiv), NB_OP'(MdDivu): begin
                core_load = 1'b1;
                cnt_d     = '0;
                sign_rs_d = op_signed & md.i_rs_data[NB_REG-1];
                sign_rt_d = op_signed & md.i_rt_data[NB_REG-1];
                is_div_d  = (op == NB_OP'(MdDiv)) || (op == NB_OP'(MdDivu));
                dz_d      = is_div_d && (md.i_rt_data == '0);
                state_d   = StRun;
              end
              NB_OP'(MdMthi): hi_d = md.i_rs_data;
              NB_OP'(MdMtlo): lo_d = md.i_rs_data;
              default: ;
            endcase
          end
        end
        StRun: begin
          core_step = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == NB_CNT'(NB_REG - 1)) begin
            cnt_d   = '0;
            state_d = StFix;
          end
        end
        StFix: begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = dz_q ? '1 : quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sign_rs_q <= 1'b0;
      sign_rt_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sign_rs_q <= sign_rs_d;
      sign_rt_q <= sign_rt_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign md.o_hi    = hi_q;
  assign md.o_lo    = lo_q;
  assign md.o_busy  = busy;
  assign md.o_done  = done_q;
  assign md.o_stall = busy & (md.i_start | md.i_read_req);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: vector table plus random ops through a
// result scoreboard, then hazard, flush and reset sequences.
module tb_ex_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ex_muldiv_ctrl_if md_bus ();

  ex_muldiv_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .md      (md_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] rs,
                                        input logic [31:0] rt);
    longint p;
    int     q;
    int     r;
    case (op)
      3'd0: begin
        p = longint'($signed(rs)) * longint'($signed(rt));
        return 64'(p);
      end
      3'd1: return {32'd0, rs} * {32'd0, rt};
      3'd2: begin
        if (rt == 32'd0) return {rs, 32'hFFFFFFFF};
        if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = $signed(rs) / $signed(rt);
        r = $signed(rs) % $signed(rt);
        return {32'(r), 32'(q)};
      end
      default: begin
        if (rt == 32'd0) return {rs, 32'hFFFFFFFF};
        return {rs % rt, rs / rt};
      end
    endcase
  endfunction

  // Presents an op for one clock; called and returns at a falling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [63:0] exp, input bit push, input string name);
    exp_t e;
    md_bus.i_start   = 1'b1;
    md_bus.i_md_op   = op;
    md_bus.i_rs_data = rs;
    md_bus.i_rt_data = rt;
    if (push) begin
      e.res  = exp;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    md_bus.i_start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles);
    exp_t e;
    int   n;
    n           = 0;
    busy_cycles = 0;
    while (md_bus.o_done !== 1'b1 && n < 100) begin
      if (md_bus.o_busy === 1'b1) busy_cycles++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL done_timeout: got no o_done in %0d cycles, required a pulse", n);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got o_done with hi=%h lo=%h, required no result",
               md_bus.o_hi, md_bus.o_lo);
    end else begin
      e = sb.pop_front();
      errors += ({md_bus.o_hi, md_bus.o_lo} !== e.res) ? 1 : 0;
      if ({md_bus.o_hi, md_bus.o_lo} !== e.res)
        $display("FAIL %s: got %h, required %h", e.name, {md_bus.o_hi, md_bus.o_lo}, e.res);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int n;
    bit done_seen;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[4]  = '{3'd3, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF};
    vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{3'd1, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
    vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};

    rst_n             = 1'b0;
    md_bus.i_start    = 1'b0;
    md_bus.i_md_op    = 3'd0;
    md_bus.i_rs_data  = 32'd0;
    md_bus.i_rt_data  = 32'd0;
    md_bus.i_read_req = 1'b0;
    md_bus.i_flush    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_hi", 64'(md_bus.o_hi), 64'd0);
    check("reset_lo", 64'(md_bus.o_lo), 64'd0);
    check("reset_busy", 64'(md_bus.o_busy), 64'd0);
    check("reset_done", 64'(md_bus.o_done), 64'd0);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, {vecs[i].hi, vecs[i].lo}, 1'b1,
            $sformatf("vec%0d", i));
      wait_done(bc);
      if (i == 0) begin
        check("busy_cycles", 64'(bc), 64'd33);
        check("busy_at_done", 64'(md_bus.o_busy), 64'd0);
        @(negedge clk);
        check("done_pulse_width", 64'(md_bus.o_done), 64'd0);
      end
    end

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      issue(op, a, b, model(op, a, b), 1'b1, $sformatf("rand%0d_op%0d", i, op));
      wait_done(bc);
    end

    // Hazards: MFHI and a second MULTU held while a MULT is in flight.
    issue(3'd0, 32'd1234, 32'hFFFFD3D2, model(3'd0, 32'd1234, 32'hFFFFD3D2), 1'b1, "haz_mult");
    md_bus.i_start    = 1'b1;
    md_bus.i_md_op    = 3'd1;
    md_bus.i_rs_data  = 32'd3;
    md_bus.i_rt_data  = 32'd5;
    md_bus.i_read_req = 1'b1;
    n = 0;
    while (md_bus.o_busy === 1'b1 && n < 100) begin
      check("stall_while_busy", 64'(md_bus.o_stall), 64'd1);
      @(negedge clk);
      n++;
    end
    check("haz_busy_cycles", 64'(n), 64'd33);
    check("stall_done_cycle", 64'(md_bus.o_stall), 64'd0);
    wait_done(bc);
    begin
      exp_t e;
      e.res  = 64'd15;
      e.name = "haz_multu";
      sb.push_back(e);
    end
    @(negedge clk);
    md_bus.i_start    = 1'b0;
    md_bus.i_read_req = 1'b0;
    check("held_op_accepted", 64'(md_bus.o_busy), 64'd1);
    wait_done(bc);

    // MTLO/MTHI write directly with no busy period.
    issue(3'd5, 32'h1234, 32'd0, 64'd0, 1'b0, "");
    check("mtlo_lo", 64'(md_bus.o_lo), 64'h1234);
    check("mtlo_busy", 64'(md_bus.o_busy), 64'd0);
    issue(3'd4, 32'hAAAA, 32'd0, 64'd0, 1'b0, "");
    issue(3'd5, 32'h5555, 32'd0, 64'd0, 1'b0, "");
    check("mthi_hi", 64'(md_bus.o_hi), 64'hAAAA);
    check("mtlo2_lo", 64'(md_bus.o_lo), 64'h5555);

    // Flush at RUN cycle 10.
    issue(3'd0, 32'd3, 32'd3, 64'd0, 1'b0, "");
    repeat (10) @(negedge clk);
    md_bus.i_flush = 1'b1;
    @(negedge clk);
    md_bus.i_flush = 1'b0;
    check("flush_run_busy", 64'(md_bus.o_busy), 64'd0);
    check("flush_run_hilo", {md_bus.o_hi, md_bus.o_lo}, {32'hAAAA, 32'h5555});
    done_seen = 1'b0;
    repeat (40) begin
      if (md_bus.o_done === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    check("flush_run_no_done", 64'(done_seen), 64'd0);
    check("flush_run_hilo_late", {md_bus.o_hi, md_bus.o_lo}, {32'hAAAA, 32'h5555});

    // Flush drops a same-cycle MTLO.
    md_bus.i_flush = 1'b1;
    issue(3'd5, 32'h9999, 32'd0, 64'd0, 1'b0, "");
    md_bus.i_flush = 1'b0;
    check("flush_drops_mtlo", 64'(md_bus.o_lo), 64'h5555);

    // Flush in the FIX cycle.
    issue(3'd0, 32'd2, 32'd3, 64'd0, 1'b0, "");
    repeat (32) @(negedge clk);
    check("fix_still_busy", 64'(md_bus.o_busy), 64'd1);
    md_bus.i_flush = 1'b1;
    @(negedge clk);
    md_bus.i_flush = 1'b0;
    check("flush_fix_busy", 64'(md_bus.o_busy), 64'd0);
    check("flush_fix_done", 64'(md_bus.o_done), 64'd0);
    check("flush_fix_hilo", {md_bus.o_hi, md_bus.o_lo}, {32'hAAAA, 32'h5555});
    @(negedge clk);
    check("flush_fix_done_late", 64'(md_bus.o_done), 64'd0);

    // Asynchronous reset mid-RUN.
    issue(3'd0, 32'd5, 32'd5, 64'd0, 1'b0, "");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_hi", 64'(md_bus.o_hi), 64'd0);
    check("rst_mid_lo", 64'(md_bus.o_lo), 64'd0);
    check("rst_mid_busy", 64'(md_bus.o_busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_busy", 64'(md_bus.o_busy), 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
